// File: rtl/tri_sum_unwind.sv
// Reverse unwinder for the nested triangular-sum accumulator: loads a final
// (k, i) pair and walks the outer/inner loops backwards until k returns to 1.
module tri_sum_unwind #(
  parameter int WIDTH   = 11,
  parameter int I_LIMIT = 60
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] k_in,
  input  logic [WIDTH-1:0] i_in,
  output logic [2:0]       turn,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] j,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_CHECK = 3'd0,
    S_SUB   = 3'd1,
    S_DEC   = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4,
    S_IDLE  = 3'd5
  } state_t;

  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(I_LIMIT);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  state_t           turn_q, turn_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic [WIDTH-1:0] i_q, i_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] step;

  always_ff @(posedge clk) begin
    if (rst) begin
      turn_q <= S_IDLE;
      k_q    <= ONE;
      i_q    <= ONE;
      j_q    <= '0;
    end else begin
      turn_q <= turn_d;
      k_q    <= k_d;
      i_q    <= i_d;
      j_q    <= j_d;
    end
  end

  always_comb begin
    turn_d = turn_q;
    k_d    = k_q;
    i_d    = i_q;
    j_d    = j_q;
    step   = i_q - j_q;
    case (turn_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          k_d    = k_in;
          i_d    = i_in;
          j_d    = '0;
          turn_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (i_q > LIMIT)      turn_d = S_ERR;
        else if (i_q <= ONE)  turn_d = S_DONE;
        else                  turn_d = S_DEC;
      end
      S_DEC: begin
        i_d    = i_q - ONE;
        j_d    = '0;
        turn_d = S_SUB;
      end
      S_SUB: begin
        if (j_q < i_q) begin
          // Subtracting would take k to zero or below: trap instead of wrapping.
          if (k_q <= step) begin
            turn_d = S_ERR;
          end else begin
            k_d = k_q - step;
            j_d = j_q + ONE;
          end
        end else begin
          turn_d = S_CHECK;
        end
      end
      default: turn_d = S_IDLE;
    endcase
  end

  assign turn = turn_q;
  assign k    = k_q;
  assign i    = i_q;
  assign j    = j_q;
  assign done = (turn_q == S_DONE);
  assign err  = (turn_q == S_ERR);

endmodule

// File: tb/tb_tri_sum_unwind.sv
// Randomized scoreboard bench for tri_sum_unwind: a loop-level reference
// model predicts the final state and latency of each accepted start.
module tb_tri_sum_unwind;
  localparam int WIDTH   = 11;
  localparam int I_LIMIT = 60;
  localparam int BUDGET  = 2500;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] k_in, i_in;
  logic [2:0]       turn;
  logic [WIDTH-1:0] k, i, j;
  logic             done, err;

  tri_sum_unwind #(.WIDTH(WIDTH), .I_LIMIT(I_LIMIT)) dut (
    .clk(clk), .rst(rst), .start(start), .k_in(k_in), .i_in(i_in),
    .turn(turn), .k(k), .i(i), .j(j), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int turn; int k; int i; int j; int lat; int start_cyc; int kin; int iin;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic prev_de = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: walk outer index m = n-1..1; each outer pass removes
  // m + (m-1) + ... + 1 from k and costs m+3 edges, plus one final CHECK edge.
  function automatic exp_t model(input int kin, input int iin);
    exp_t e;
    int kk, lat;
    e.kin = kin; e.iin = iin; e.start_cyc = 0;
    e.k = kin; e.i = iin; e.j = 0; e.lat = 1;
    if (iin > I_LIMIT) begin e.turn = 4; return e; end
    if (iin <= 1)      begin e.turn = 3; return e; end
    kk = kin; lat = 0;
    for (int m = iin - 1; m >= 1; m--) begin
      lat += 2;
      for (int jj = 0; jj < m; jj++) begin
        if (kk <= m - jj) begin
          e.turn = 4; e.k = kk; e.i = m; e.j = jj; e.lat = lat + 1;
          return e;
        end
        kk -= m - jj;
        lat++;
      end
      lat++;
    end
    e.turn = 3; e.k = kk; e.i = 1; e.j = 1; e.lat = lat + 1;
    return e;
  endfunction

  // Monitor: on each rising done/err, pop and compare the prediction.
  always @(posedge clk) begin
    #1;
    if ((done || err) && !prev_de) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_completion_turn", int'(turn), 5);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("turn", int'(turn), e.turn);
        chk("done", int'(done), int'(e.turn == 3));
        chk("err", int'(err), int'(e.turn == 4));
        chk("k", int'(k), e.k);
        chk("i", int'(i), e.i);
        chk("j", int'(j), e.j);
        chk("latency", cyc - e.start_cyc, e.lat);
        $display("txn k_in=%0d i_in=%0d -> turn=%0d k=%0d i=%0d j=%0d lat=%0d",
                 e.kin, e.iin, turn, k, i, j, cyc - e.start_cyc);
      end
    end
    prev_de = done || err;
  end

  task automatic wait_idle();
    int budget = BUDGET;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() != 0) begin
      chk("completion_timeout_pending", exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic issue(input int kin, input int iin);
    exp_t e;
    @(negedge clk);
    e = model(kin, iin);
    e.start_cyc = cyc + 1;
    exp_q.push_back(e);
    start = 1'b1;
    k_in  = WIDTH'(kin);
    i_in  = WIDTH'(iin);
    @(negedge clk);
    start = 1'b0;
    k_in  = WIDTH'($urandom);
    i_in  = WIDTH'($urandom);
  endtask

  task automatic run(input int kin, input int iin);
    issue(kin, iin);
    wait_idle();
  endtask

  // Start pulses while busy must be ignored.
  task automatic run_noisy(input int kin, input int iin);
    issue(kin, iin);
    for (int p = 0; p < 3; p++) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      k_in  = WIDTH'($urandom_range(1, 2047));
      i_in  = WIDTH'($urandom_range(0, 30));
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    int n, kin, budget;
    rst = 1'b1; start = 1'b0; k_in = '0; i_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_turn", int'(turn), 5);
    chk("rst_k", int'(k), 1);
    chk("rst_i", int'(i), 1);
    chk("rst_j", int'(j), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);

    run(11, 4);
    repeat (4) @(negedge clk);
    chk("done_sticky_turn", int'(turn), 3);
    chk("done_sticky_k", int'(k), 1);
    run(1772, 22);
    run(10, 4);
    repeat (4) @(negedge clk);
    chk("err_sticky_turn", int'(turn), 4);
    chk("err_sticky_k", int'(k), 1);
    chk("err_sticky_j", int'(j), 0);
    run(11, 4);
    run(5, 61);
    run(7, 0);
    run(9, 1);
    run(2025, 23);
    run_noisy(1772, 22);
    run_noisy(21, 5);

    for (int t = 0; t < 24; t++) begin
      case ($urandom_range(0, 2))
        0: begin
          n = $urandom_range(0, 23);
          kin = (n >= 2) ? 1 + ((n - 1) * n * (n + 1)) / 6 : $urandom_range(0, 2047);
        end
        1: begin n = $urandom_range(0, 30); kin = $urandom_range(0, 2047); end
        default: begin n = $urandom_range(0, 2047); kin = $urandom_range(0, 2047); end
      endcase
      run(kin, n);
    end

    // Reset asserted in the middle of an unwind (not scoreboarded).
    @(negedge clk);
    start = 1'b1; k_in = WIDTH'(1772); i_in = WIDTH'(22);
    @(negedge clk);
    start = 1'b0;
    budget = 50;
    while (turn != 3'd1 && budget > 0) begin @(negedge clk); budget--; end
    chk("reach_sub_turn", int'(turn), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_turn", int'(turn), 5);
    chk("midrst_k", int'(k), 1);
    chk("midrst_i", int'(i), 1);
    chk("midrst_j", int'(j), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_err", int'(err), 0);
    repeat (3) @(negedge clk);
    chk("midrst_hold_turn", int'(turn), 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
